// File: rtl/pipelined_addsub.sv
// pipelined_addsub: pipelined integer add/subtract unit with a tag, a valid/ready
// handshake, a squash input and status flags.
// The WIDTH-bit carry chain is split into STAGES registered segments of WIDTH/STAGES bits.
// Optional saturation mode is enabled by defining PIPELINED_ADDSUB_SAT_EN. It adds the
// in_sat port. When the macro is undefined, results always wrap modulo 2^WIDTH.
module pipelined_addsub #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4,
  parameter int TAG_W  = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
`ifdef PIPELINED_ADDSUB_SAT_EN
  input  logic             in_sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if ((WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES");
  end

  // Per-stage registers. Stage k holds the sum bits resolved so far, the full
  // operands (the upper bits are still needed), and the carry out of segment k.
  logic [STAGES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]  sum_q   [STAGES];
  logic [WIDTH-1:0]  sum_d   [STAGES];
  logic [WIDTH-1:0]  a_q     [STAGES];
  logic [WIDTH-1:0]  a_d     [STAGES];
  logic [WIDTH-1:0]  bp_q    [STAGES];
  logic [WIDTH-1:0]  bp_d    [STAGES];
  logic              carry_q [STAGES];
  logic              carry_d [STAGES];
  logic [TAG_W-1:0]  tag_q   [STAGES];
  logic [TAG_W-1:0]  tag_d   [STAGES];
`ifdef PIPELINED_ADDSUB_SAT_EN
  logic              sat_q   [STAGES];
  logic              sat_d   [STAGES];
  logic              stg_sat [STAGES];
`endif

  // Flags are produced by the last stage and held with the result.
  logic ovf_q, ovf_d;
  logic zero_q, zero_d;

  // Stage inputs: stage 0 takes the ports, stage k takes the registers of stage k-1.
  logic [STAGES-1:0] stg_valid;
  logic [WIDTH-1:0]  stg_a   [STAGES];
  logic [WIDTH-1:0]  stg_bp  [STAGES];
  logic [WIDTH-1:0]  stg_sum [STAGES];
  logic              stg_c   [STAGES];
  logic [TAG_W-1:0]  stg_tag [STAGES];
  logic [SEG:0]      seg_res;
  logic              advance;

  // Handshake, segment adders and last-stage flag/saturation logic.
  always_comb begin
    advance  = !valid_q[LAST] || out_ready;
    in_ready = advance;
    seg_res  = '0;

    stg_valid[0] = in_valid;
    stg_a[0]     = in_a;
    stg_bp[0]    = in_sub ? ~in_b : in_b;
    stg_c[0]     = in_sub ? ~in_cin : in_cin;
    stg_sum[0]   = '0;
    stg_tag[0]   = in_tag;
`ifdef PIPELINED_ADDSUB_SAT_EN
    stg_sat[0]   = in_sat;
`endif
    for (int k = 1; k < STAGES; k++) begin
      stg_valid[k] = valid_q[k-1];
      stg_a[k]     = a_q[k-1];
      stg_bp[k]    = bp_q[k-1];
      stg_c[k]     = carry_q[k-1];
      stg_sum[k]   = sum_q[k-1];
      stg_tag[k]   = tag_q[k-1];
`ifdef PIPELINED_ADDSUB_SAT_EN
      stg_sat[k]   = sat_q[k-1];
`endif
    end

    for (int k = 0; k < STAGES; k++) begin
      seg_res = {1'b0, stg_a[k][k*SEG +: SEG]} + {1'b0, stg_bp[k][k*SEG +: SEG]}
                + {{SEG{1'b0}}, stg_c[k]};
      valid_d[k]               = stg_valid[k];
      sum_d[k]                 = stg_sum[k];
      sum_d[k][k*SEG +: SEG]   = seg_res[SEG-1:0];
      carry_d[k]               = seg_res[SEG];
      a_d[k]                   = stg_a[k];
      bp_d[k]                  = stg_bp[k];
      tag_d[k]                 = stg_tag[k];
`ifdef PIPELINED_ADDSUB_SAT_EN
      sat_d[k]                 = stg_sat[k];
`endif
    end

    ovf_d = (stg_a[LAST][WIDTH-1] == stg_bp[LAST][WIDTH-1]) &&
            (sum_d[LAST][WIDTH-1] != stg_a[LAST][WIDTH-1]);
`ifdef PIPELINED_ADDSUB_SAT_EN
    if (stg_sat[LAST] && ovf_d) begin
      sum_d[LAST] = stg_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    zero_d = (sum_d[LAST] == '0);
  end

  // Pipeline registers: the whole pipe shifts on advance, flush clears every valid bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k]   <= '0;
        a_q[k]     <= '0;
        bp_q[k]    <= '0;
        carry_q[k] <= 1'b0;
        tag_q[k]   <= '0;
`ifdef PIPELINED_ADDSUB_SAT_EN
        sat_q[k]   <= 1'b0;
`endif
      end
    end else begin
      if (flush) begin
        valid_q <= '0;
      end else if (advance) begin
        valid_q <= valid_d;
      end
      if (advance) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
        for (int k = 0; k < STAGES; k++) begin
          sum_q[k]   <= sum_d[k];
          a_q[k]     <= a_d[k];
          bp_q[k]    <= bp_d[k];
          carry_q[k] <= carry_d[k];
          tag_q[k]   <= tag_d[k];
`ifdef PIPELINED_ADDSUB_SAT_EN
          sat_q[k]   <= sat_d[k];
`endif
        end
      end
    end
  end

  assign out_valid = valid_q[LAST];
  assign out_sum   = sum_q[LAST];
  assign out_tag   = tag_q[LAST];
  assign out_cout  = carry_q[LAST];
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;
  assign out_neg   = sum_q[LAST][WIDTH-1];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Testbench for pipelined_addsub (WIDTH=64, STAGES=4, TAG_W=6).
// Stimulus pushes the expected result into a queue when the unit accepts the beat.
// An independent monitor compares the queue head with whatever the unit presents.
module tb_pipelined_addsub;

  localparam int WIDTH  = 64;
  localparam int STAGES = 4;
  localparam int TAG_W  = 6;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_cin;
  logic [TAG_W-1:0] in_tag;
`ifdef PIPELINED_ADDSUB_SAT_EN
  logic             in_sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [TAG_W-1:0] out_tag;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;
  logic             out_neg;

  typedef struct {
    logic [63:0] sum;
    logic [5:0]  tag;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Directed stream vectors with hand-computed results.
  logic [63:0] va [8];
  logic [63:0] vb [8];
  logic [63:0] vs [8];
  logic        vsub [8];
  logic        vcin [8];
  logic        vcout [8];
  logic        vovf [8];

  localparam logic [63:0] SUB_OP = 64'h2DAB324F789F34FF;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_sub(in_sub),
    .in_cin(in_cin),
    .in_tag(in_tag),
`ifdef PIPELINED_ADDSUB_SAT_EN
    .in_sat(in_sat),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_tag(out_tag),
    .out_cout(out_cout),
    .out_ovf(out_ovf),
    .out_zero(out_zero),
    .out_neg(out_neg)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offer one beat (called at posedge+1); queue its expected result once it is accepted.
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic sub,
                               input logic cin, input logic [5:0] tag, input logic [63:0] esum,
                               input logic ecout, input logic eovf);
    exp_t e;
    int   waited = 0;
    bit   done   = 0;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_cin   = cin;
    in_tag   = tag;
    in_valid = 1'b1;
    e.sum  = esum;
    e.tag  = tag;
    e.cout = ecout;
    e.ovf  = eovf;
    e.zero = (esum == 64'd0);
    e.neg  = esum[63];
    while (!done) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        exp_q.push_back(e);
        done = 1;
      end else if (waited >= 50) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL accept_timeout: tag %0d not accepted within 50 cycles", tag);
        done = 1;
      end
      waited++;
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1 of the cycle after acceptance: result must appear exactly STAGES cycles after accept.
  task automatic checkLatency(input string name);
    for (int i = 1; i < STAGES; i++) begin
      @(negedge clk);
      checkOutput({name, "_early_valid"}, {63'd0, out_valid}, 64'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput({name, "_valid_at_latency"}, {63'd0, out_valid}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input string name);
    int c = 0;
    while (exp_q.size() != 0 && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
    checkOutput({name, "_pending_results"}, 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: check the handshake every cycle and compare any presented result with the queue head.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      checkOutput("in_ready", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_result: tag %0d sum 0x%0h with nothing expected", out_tag, out_sum);
        end else begin
          mon_e = exp_q[0];
          checkOutput("out_sum",  out_sum, mon_e.sum);
          checkOutput("out_tag",  {58'd0, out_tag}, {58'd0, mon_e.tag});
          checkOutput("out_cout", {63'd0, out_cout}, {63'd0, mon_e.cout});
          checkOutput("out_ovf",  {63'd0, out_ovf},  {63'd0, mon_e.ovf});
          checkOutput("out_zero", {63'd0, out_zero}, {63'd0, mon_e.zero});
          checkOutput("out_neg",  {63'd0, out_neg},  {63'd0, mon_e.neg});
          if (out_ready === 1'b1) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    va[0] = 64'd1;                  vb[0] = 64'd2;                  vsub[0] = 0; vcin[0] = 0;
    vs[0] = 64'd3;                  vcout[0] = 0; vovf[0] = 0;
    va[1] = 64'hFFFFFFFFFFFFFFFF;   vb[1] = 64'hFFFFFFFFFFFFFFFF;   vsub[1] = 0; vcin[1] = 0;
    vs[1] = 64'hFFFFFFFFFFFFFFFE;   vcout[1] = 1; vovf[1] = 0;
    va[2] = 64'h8000000000000000;   vb[2] = 64'h8000000000000000;   vsub[2] = 0; vcin[2] = 0;
    vs[2] = 64'd0;                  vcout[2] = 1; vovf[2] = 1;
    va[3] = 64'd10;                 vb[3] = 64'd3;                  vsub[3] = 1; vcin[3] = 0;
    vs[3] = 64'd7;                  vcout[3] = 1; vovf[3] = 0;
    va[4] = 64'd3;                  vb[4] = 64'd10;                 vsub[4] = 1; vcin[4] = 0;
    vs[4] = 64'hFFFFFFFFFFFFFFF9;   vcout[4] = 0; vovf[4] = 0;
    va[5] = 64'h8000000000000000;   vb[5] = 64'd1;                  vsub[5] = 1; vcin[5] = 0;
    vs[5] = 64'h7FFFFFFFFFFFFFFF;   vcout[5] = 1; vovf[5] = 1;
    va[6] = 64'h00000000FFFFFFFF;   vb[6] = 64'd1;                  vsub[6] = 0; vcin[6] = 1;
    vs[6] = 64'h0000000100000001;   vcout[6] = 0; vovf[6] = 0;
    va[7] = 64'h123456789ABCDEF0;   vb[7] = 64'h0FEDCBA987654321;   vsub[7] = 0; vcin[7] = 0;
    vs[7] = 64'h2222222222222211;   vcout[7] = 0; vovf[7] = 0;

    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    in_cin    = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;
`ifdef PIPELINED_ADDSUB_SAT_EN
    in_sat    = 1'b0;
`endif

    #1;
    checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset_out_sum", out_sum, 64'd0);
    checkOutput("reset_out_tag", {58'd0, out_tag}, 64'd0);
    checkOutput("reset_flags", {60'd0, out_cout, out_ovf, out_zero, out_neg}, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] basic add with signed overflow");
    applyStimulus(64'h7FFFFFFFFFFFFFFF, 64'h0000000000111111, 0, 0, 6'd5,
                  64'h8000000000111110, 0, 1);
    in_valid = 1'b0;
    checkLatency("basic_add");
    waitDrain("basic_add");

    $display("[TB] carry across every segment");
    applyStimulus(64'hFFFFFFFFFFFFFFFF, 64'd1, 0, 0, 6'd6, 64'd0, 1, 0);
    in_valid = 1'b0;
    checkLatency("carry_chain");
    waitDrain("carry_chain");

    $display("[TB] subtract with and without borrow");
    applyStimulus(SUB_OP, SUB_OP, 1, 0, 6'd7, 64'd0, 1, 0);
    applyStimulus(SUB_OP, SUB_OP, 1, 1, 6'd8, 64'hFFFFFFFFFFFFFFFF, 0, 0);
    in_valid = 1'b0;
    waitDrain("subtract");

    $display("[TB] backpressure stream of 8 operations");
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          applyStimulus(va[i], vb[i], vsub[i], vcin[i], 6'(i), vs[i], vcout[i], vovf[i]);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    waitDrain("backpressure");

    $display("[TB] flush with three operations in flight");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(va[i], vb[i], vsub[i], vcin[i], 6'(10 + i), vs[i], vcout[i], vovf[i]);
    end
    in_a     = va[7];
    in_b     = vb[7];
    in_sub   = 1'b0;
    in_cin   = 1'b0;
    in_tag   = 6'd13;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
    fork
      begin
        @(negedge clk);
        checkOutput("flush_first_cycle_valid", {63'd0, out_valid}, 64'd0);
      end
    join_none
    applyStimulus(va[3], vb[3], vsub[3], vcin[3], 6'd14, vs[3], vcout[3], vovf[3]);
    in_valid = 1'b0;
    checkLatency("after_flush");
    waitDrain("after_flush");

    $display("[TB] asynchronous reset mid-stream");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(va[i], vb[i], vsub[i], vcin[i], 6'(20 + i), vs[i], vcout[i], vovf[i]);
    end
    in_valid = 1'b0;
    #1;
    checkOutput("pre_reset_valid", {63'd0, out_valid}, 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("async_reset_sum", out_sum, 64'd0);
    checkOutput("async_reset_tag", {58'd0, out_tag}, 64'd0);
    checkOutput("async_reset_flags", {60'd0, out_cout, out_ovf, out_zero, out_neg}, 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(va[7], vb[7], vsub[7], vcin[7], 6'd30, vs[7], vcout[7], vovf[7]);
    in_valid = 1'b0;
    checkLatency("post_reset");
    waitDrain("post_reset");

`ifdef PIPELINED_ADDSUB_SAT_EN
    $display("[TB] saturating add");
    in_sat = 1'b1;
    applyStimulus(64'h7FFFFFFFFFFFFFFF, 64'd1, 0, 0, 6'd40, 64'h7FFFFFFFFFFFFFFF, 0, 1);
    in_valid = 1'b0;
    in_sat   = 1'b0;
    waitDrain("saturate");
`else
    $display("[TB] wrapping add on overflow");
    applyStimulus(64'h7FFFFFFFFFFFFFFF, 64'd1, 0, 0, 6'd40, 64'h8000000000000000, 0, 1);
    in_valid = 1'b0;
    waitDrain("wrap");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
